// File: rtl/decrypt_pkg.sv
// Shared constants and types for the decrypt scheduler: datapath widths,
// function-select field position and the scheduler state encoding.
package decrypt_pkg;

  localparam int CIPHER_W     = 78;
  localparam int PLAIN_W      = 60;
  localparam int FUNC_SEL_LSB = 4;
  localparam int FUNC_SEL_MSB = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic [FUNC_SEL_MSB-FUNC_SEL_LSB:0] func_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above i_ptr,
// wrapping. Returns a one-hot grant, the winner index and an any-request flag.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  int w_j;

  // Walk offsets from farthest to nearest so the nearest requester overwrites.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
      if (i_req[w_j[IDX_W-1:0]]) begin
        o_grant = NUM_REQ'(1) << w_j[IDX_W-1:0];
        o_idx   = w_j[IDX_W-1:0];
        o_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decrypt_scheduler.sv
// Shares one Decrypter datapath between NUM_REQ requesters, one transaction at a
// time. Optional per-function completion counters under `DEC_SCHED_STATS_EN.
module decrypt_scheduler
  import decrypt_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DEC_LATENCY = 2,
  parameter int CNT_W       = 16
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*CIPHER_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [CIPHER_W-1:0]           dec_data,
  input  logic [PLAIN_W-1:0]            dec_result,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [PLAIN_W-1:0]            rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic [1:0]                    rsp_func,
  output logic                          busy,
  output logic [4*CNT_W-1:0]            stat_count,
  output state_t                        o_dbg_state
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int CW   = $clog2(DEC_LATENCY + 1);

  state_t                r_state, w_state_nxt;
  logic [ID_W-1:0]       r_rr_ptr, r_id, r_rsp_id;
  logic [CW-1:0]         r_cnt;
  logic [CIPHER_W-1:0]   r_dec_data;
  func_t                 r_func, r_rsp_func;
  logic                  r_rsp_valid;
  logic [PLAIN_W-1:0]    r_rsp_data;
  logic [NUM_REQ-1:0]    w_grant;
  logic [ID_W-1:0]       w_win;
  logic                  w_any, w_accept, w_capture, w_release;
  logic [CIPHER_W-1:0]   w_req_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign w_req_arr[i] = req_data[CIPHER_W*i +: CIPHER_W];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(ID_W)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_win),
    .o_any   (w_any)
  );

  // Both channels use valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; valid never drops and data never changes
  // before that edge. req_ready is a grant offered only in IDLE.
  assign req_ready = (Rst_n && r_state == IDLE) ? w_grant : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      IDLE: if (w_any) begin
        w_accept    = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: if (r_cnt == CW'(1)) begin
        w_capture   = 1'b1;
        w_state_nxt = RESP;
      end
      RESP: if (rsp_ready) begin
        w_release   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // dec_data only moves on acceptance, so the datapath input is stable through WAIT/RESP.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_func      <= '0;
      r_cnt       <= '0;
      r_dec_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_rsp_func  <= '0;
    end else begin
      if (w_accept) begin
        r_dec_data <= w_req_arr[w_win];
        r_id       <= w_win;
        r_func     <= w_req_arr[w_win][FUNC_SEL_MSB:FUNC_SEL_LSB];
        r_cnt      <= CW'(DEC_LATENCY);
        r_rr_ptr   <= (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + ID_W'(1);
      end
      if (r_state == WAIT) r_cnt <= r_cnt - 1'b1;
      if (w_capture) begin
        r_rsp_data  <= dec_result;
        r_rsp_id    <= r_id;
        r_rsp_func  <= r_func;
        r_rsp_valid <= 1'b1;
      end
      if (w_release) r_rsp_valid <= 1'b0;
    end
  end

  assign dec_data    = r_dec_data;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_id      = r_rsp_id;
  assign rsp_func    = r_rsp_func;
  assign busy        = (r_state != IDLE);
  assign o_dbg_state = r_state;

`ifdef DEC_SCHED_STATS_EN
  logic [CNT_W-1:0] r_stat [4];

  // Saturating counters; only a reset clears them.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      for (int f = 0; f < 4; f++) r_stat[f] <= '0;
    end else if (w_release && (r_stat[r_rsp_func] != '1)) begin
      r_stat[r_rsp_func] <= r_stat[r_rsp_func] + CNT_W'(1);
    end
  end

  for (genvar f = 0; f < 4; f++) begin : g_stat
    assign stat_count[CNT_W*f +: CNT_W] = r_stat[f];
  end
`else
  assign stat_count = '0;
`endif

endmodule

// File: tb/tb_decrypt_scheduler.sv
// Bench for decrypt_scheduler: transaction-level model checked every cycle,
// response scoreboard, directed scenarios and a randomized phase.
module tb_decrypt_scheduler;
  import decrypt_pkg::*;

  localparam int NUM_REQ     = 4;
  localparam int DEC_LATENCY = 2;
`ifdef DEC_SCHED_STATS_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int EXP_W = ID_W + 2 + PLAIN_W;

  // ---------------- clock / reset ----------------
  logic Clk   = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*CIPHER_W-1:0] req_data;
  logic [NUM_REQ-1:0]          req_ready;
  logic [CIPHER_W-1:0]         dec_data;
  logic [PLAIN_W-1:0]          dec_result;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [PLAIN_W-1:0]          rsp_data;
  logic [ID_W-1:0]             rsp_id;
  logic [1:0]                  rsp_func;
  logic                        busy;
  logic [4*CNT_W-1:0]          stat_count;
  state_t                      o_dbg_state;

  decrypt_scheduler #(.NUM_REQ(NUM_REQ), .DEC_LATENCY(DEC_LATENCY), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .dec_data(dec_data), .dec_result(dec_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_func(rsp_func), .busy(busy), .stat_count(stat_count),
    .o_dbg_state(o_dbg_state)
  );

  // Stand-in Decrypter: result of golden() valid DEC_LATENCY-1 edges after dec_data changes.
  function automatic logic [PLAIN_W-1:0] golden(input logic [CIPHER_W-1:0] c);
    return c[77:18] ^ {c[17:0], c[77:36]};
  endfunction

  logic [PLAIN_W-1:0] dec_pipe = '0;
  always @(posedge Clk) dec_pipe <= golden(dec_data);
  assign dec_result = dec_pipe;

  // ---------------- checking infrastructure ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [CIPHER_W-1:0] src_q [NUM_REQ][$];
  logic [EXP_W-1:0]    exp_q[$];
  int                  obs_grants[$];
  func_t               obs_funcs[$];
  bit                  rand_gap = 1'b0;

  // ---------------- behavioural model ----------------
  int                  m_phase = 0;   // 0 idle, 1 decrypting, 2 response offered
  int                  m_rr = 0, m_edge = 0, m_due = 0, m_id = 0;
  bit                  m_init = 1'b0;
  logic [CIPHER_W-1:0] m_dec_data = '0, m_cipher = '0;
  logic                m_rsp_valid = 1'b0;
  logic [PLAIN_W-1:0]  m_rsp_data = '0;
  logic [ID_W-1:0]     m_rsp_id = '0;
  func_t               m_rsp_func = '0;
  int                  m_stat[4];
  logic [NUM_REQ-1:0]          prev_pend = '0;
  logic [NUM_REQ*CIPHER_W-1:0] prev_data = '0;

  int                  c_win;
  logic [NUM_REQ-1:0]  c_rdy;
  logic [4*CNT_W-1:0]  c_stat;
  state_t              c_state;
  logic [EXP_W-1:0]    c_exp;

  always @(negedge Clk) begin
    c_win = -1;
    for (int k = 0; k < NUM_REQ; k++)
      if (c_win < 0 && req_valid[(m_rr + k) % NUM_REQ]) c_win = (m_rr + k) % NUM_REQ;
    c_rdy = '0;
    if (Rst_n && m_phase == 0 && c_win >= 0) c_rdy[c_win] = 1'b1;

    if (m_init) begin
      chk("req_ready", req_ready, c_rdy);
      chk("dec_data", dec_data, m_dec_data);
      chk("rsp_valid", rsp_valid, m_rsp_valid);
      chk("rsp_data", rsp_data, m_rsp_data);
      chk("rsp_id", rsp_id, m_rsp_id);
      chk("rsp_func", rsp_func, m_rsp_func);
      chk("busy", busy, m_phase != 0);
      c_state = (m_phase == 0) ? IDLE : (m_phase == 1) ? WAIT : RESP;
      chk("state", o_dbg_state, c_state);
      c_stat = '0;
`ifdef DEC_SCHED_STATS_EN
      for (int f = 0; f < 4; f++) c_stat[f*CNT_W +: CNT_W] = CNT_W'(m_stat[f]);
`endif
      chk("stat_count", stat_count, c_stat);
      for (int i = 0; i < NUM_REQ; i++)
        if (prev_pend[i])
          chk("proto_hold", {req_valid[i], req_data[i*CIPHER_W +: CIPHER_W]},
              {1'b1, prev_data[i*CIPHER_W +: CIPHER_W]});
      if (Rst_n && rsp_valid && rsp_ready) begin
        chk("sb_pending", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          c_exp = exp_q.pop_front();
          chk("sb_rsp", {rsp_id, rsp_func, rsp_data}, c_exp);
        end
        obs_funcs.push_back(rsp_func);
      end
      if (Rst_n)
        for (int i = 0; i < NUM_REQ; i++)
          if (req_valid[i] && req_ready[i]) obs_grants.push_back(i);
    end
    prev_pend = req_valid & ~req_ready;
    prev_data = req_data;

    // Advance the model across the coming rising edge.
    m_edge++;
    if (!Rst_n) begin
      m_init = 1'b1; m_phase = 0; m_rr = 0; m_dec_data = '0;
      m_rsp_valid = 1'b0; m_rsp_data = '0; m_rsp_id = '0; m_rsp_func = '0;
      for (int f = 0; f < 4; f++) m_stat[f] = 0;
      exp_q.delete();
    end else if (m_phase == 0) begin
      if (c_win >= 0) begin
        m_cipher   = req_data[c_win*CIPHER_W +: CIPHER_W];
        m_dec_data = m_cipher;
        m_id       = c_win;
        m_rr       = (c_win + 1) % NUM_REQ;
        m_due      = m_edge + DEC_LATENCY;
        m_phase    = 1;
        exp_q.push_back({ID_W'(c_win), m_cipher[5:4], golden(m_cipher)});
      end
    end else if (m_phase == 1) begin
      if (m_edge == m_due) begin
        m_phase = 2; m_rsp_valid = 1'b1; m_rsp_data = golden(m_cipher);
        m_rsp_id = ID_W'(m_id); m_rsp_func = m_cipher[5:4];
      end
    end else if (rsp_ready) begin
      m_phase = 0; m_rsp_valid = 1'b0;
      if (m_stat[m_rsp_func] < (1 << CNT_W) - 1) m_stat[m_rsp_func]++;
    end
  end

  // ---------------- requester driver ----------------
  logic [NUM_REQ-1:0] taken;
  initial begin
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(negedge Clk);
      taken = req_valid & req_ready;
      @(posedge Clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (taken[i]) begin
          void'(src_q[i].pop_front());
          req_valid[i] = 1'b0;
        end
        if (!req_valid[i] && src_q[i].size() > 0 && (!rand_gap || $urandom_range(0, 1) == 1)) begin
          req_valid[i] = 1'b1;
          req_data[i*CIPHER_W +: CIPHER_W] = src_q[i][0];
        end
      end
    end
  end

  function automatic logic [CIPHER_W-1:0] rand_cipher();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[CIPHER_W-1:0];
  endfunction

  function automatic int q_total();
    int s = 0;
    for (int i = 0; i < NUM_REQ; i++) s += src_q[i].size();
    return s;
  endfunction

  task automatic reset_pulse(input int n);
    @(posedge Clk); #1;
    Rst_n = 1'b0;
    repeat (n) @(posedge Clk);
    #1;
    Rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge Clk);
      done = (m_phase == 0 && req_valid == '0 && q_total() == 0);
    end
    chk("drain_done", done, 1'b1);
    chk("drain_no_lost_rsp", exp_q.size(), 0);
  endtask

  // ---------------- directed and random stimulus ----------------
  initial begin
    logic [CIPHER_W-1:0] d;
    bit found;
    int n;
    logic [5:0] fsel [5];
    func_t      fexp [5];
    int         gexp [5];
    fsel = '{6'd15, 6'd16, 6'd47, 6'd48, 6'd63};
    fexp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    gexp = '{0, 1, 2, 3, 0};
    rsp_ready = 1'b1;
    reset_pulse(3);

    // Single request from requester 2, function select 37.
    d = rand_cipher(); d[5:0] = 6'd37;
    src_q[2].push_back(d);
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      if (req_ready[2]) begin found = 1'b1; break; end
    end
    chk("single_grant", found, 1'b1);
    n = 0;
    do begin @(negedge Clk); n++; end while (!rsp_valid && n < 20);
    chk("single_latency_edges", n - 1, 2);
    chk("single_rsp_id", rsp_id, 2);
    chk("single_rsp_func", rsp_func, 2);
    chk("single_rsp_data", rsp_data, golden(d));
    chk("single_dec_data", dec_data, d);
    wait_idle();

    // Contention from reset: every requester asks, requester 0 twice.
    reset_pulse(1);
    obs_grants.delete();
    for (int i = 0; i < NUM_REQ; i++) src_q[i].push_back(rand_cipher());
    src_q[0].push_back(rand_cipher());
    wait_idle();
    chk("contention_count", obs_grants.size(), 5);
    for (int i = 0; i < 5 && i < obs_grants.size(); i++) chk("contention_order", obs_grants[i], gexp[i]);

    // Backpressure: response held 5 cycles, a second requester waits.
    @(posedge Clk); #1;
    rsp_ready = 1'b0;
    d = rand_cipher();
    src_q[1].push_back(d);
    n = 0;
    do begin @(negedge Clk); n++; end while (!rsp_valid && n < 40);
    chk("bp_rsp_seen", rsp_valid, 1'b1);
    src_q[3].push_back(rand_cipher());
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge Clk);
      chk("bp_rsp_data", rsp_data, golden(d));
      chk("bp_rsp_id", rsp_id, 1);
      chk("bp_dec_data", dec_data, d);
      chk("bp_no_grant", req_ready, 0);
    end
    @(posedge Clk); #1;
    rsp_ready = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    chk("bp_idle_busy", busy, 1'b0);
    chk("bp_idle_grant3", req_ready, 4'b1000);
    wait_idle();

    // Function-select boundaries.
    obs_funcs.delete();
    for (int i = 0; i < 5; i++) begin
      d = rand_cipher(); d[5:0] = fsel[i];
      src_q[1].push_back(d);
    end
    wait_idle();
    chk("func_count", obs_funcs.size(), 5);
    for (int i = 0; i < 5 && i < obs_funcs.size(); i++) chk("func_boundary", obs_funcs[i], fexp[i]);

    // Reset while the datapath is busy.
    src_q[3].push_back(rand_cipher());
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      if (o_dbg_state == WAIT) begin found = 1'b1; break; end
    end
    chk("mr_wait_seen", found, 1'b1);
    reset_pulse(1);
    @(negedge Clk);
    chk("mr_busy", busy, 1'b0);
    chk("mr_dec_data", dec_data, 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge Clk);
      chk("mr_no_rsp", rsp_valid, 1'b0);
    end
    obs_grants.delete();
    src_q[3].push_back(rand_cipher());
    src_q[0].push_back(rand_cipher());
    wait_idle();
    chk("mr_first_grant", (obs_grants.size() > 0) ? obs_grants[0] : -1, 0);

    // Seventeen function-1 transactions after a clean reset.
    reset_pulse(1);
    for (int i = 0; i < 17; i++) begin
      d = rand_cipher(); d[5:4] = 2'd1;
      src_q[$urandom_range(0, NUM_REQ-1)].push_back(d);
    end
    wait_idle();
`ifdef DEC_SCHED_STATS_EN
    chk("stats_saturated", stat_count, {4'h0, 4'h0, 4'hF, 4'h0});
`else
    chk("stats_disabled", stat_count, 0);
`endif

    // Randomized traffic with random response backpressure.
    rand_gap = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(posedge Clk); #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        n = $urandom_range(0, NUM_REQ-1);
        if (src_q[n].size() < 3) src_q[n].push_back(rand_cipher());
      end
    end
    @(posedge Clk); #1;
    rsp_ready = 1'b1;
    wait_idle();
    rand_gap = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, limit 2000000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
